reset_sequencer: RTL and testbench

//  Consumes the synchronized, active-low system reset and a PLL lock indication.

---
 rtl/reset_sequencer.sv | 167 ++++++++++++++++
 tb/tb_reset_sequencer.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// Staged reset release (core -> periph -> i2c) driven by PLL lock, with lock-loss and soft-request replay.
// Optional lock-timeout forcing is compiled in with `define RST_SEQ_LOCK_TIMEOUT_EN.
module reset_sequencer #(
  parameter int unsigned STAGE_DLY    = 16,
  parameter int unsigned SOFT_PULSE   = 8,
  parameter int unsigned LOCK_TIMEOUT = 1024,
  parameter int unsigned CNT_W        = 11
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       pll_locked_i,
  input  logic       soft_rst_req_i,
  output logic       rst_core_no,
  output logic       rst_periph_no,
  output logic       rst_i2c_no,
  output logic       seq_done_o,
  output logic [1:0] rst_cause_o,
  output logic       lock_timeout_o
);

  typedef enum logic [2:0] {
    HOLD, WAIT_LOCK, DLY_CORE, DLY_PERIPH, DLY_I2C, RUN, SOFT
  } state_e;

  localparam logic [1:0] CAUSE_LOSS    = 2'b01;
  localparam logic [1:0] CAUSE_SOFT    = 2'b10;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b11;

  // The cycle spent in WAIT_LOCK after lock_s rises counts toward the core gap.
  localparam logic [CNT_W-1:0] CORE_TC  = CNT_W'((STAGE_DLY > 1) ? STAGE_DLY - 2 : 0);
  localparam logic [CNT_W-1:0] STAGE_TC = CNT_W'(STAGE_DLY - 1);
  localparam logic [CNT_W-1:0] SOFT_TC  = CNT_W'(SOFT_PULSE - 1);
  localparam logic [CNT_W-1:0] LOCK_TC  = CNT_W'(LOCK_TIMEOUT - 1);
  localparam state_e           FIRST_DLY = (STAGE_DLY > 1) ? DLY_CORE : DLY_PERIPH;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, tc_sel;
  logic             cnt_en;
  logic             sync_p0, lock_s;
  logic             lock_lost;
  logic             ev_loss, ev_soft, ev_timeout;
  logic             core_d, periph_d, i2c_d;
  logic [1:0]       cause_d;
  logic             timeout_flag;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_p0 <= 1'b0;
      lock_s  <= 1'b0;
    end else begin
      sync_p0 <= pll_locked_i;
      lock_s  <= sync_p0;
    end
  end

`ifdef RST_SEQ_LOCK_TIMEOUT_EN
  logic timeout_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) timeout_q <= 1'b0;
    else         timeout_q <= timeout_q | ev_timeout;
  end
  assign timeout_flag   = timeout_q;
  assign lock_timeout_o = timeout_q;
`else
  assign timeout_flag   = 1'b0;
  assign lock_timeout_o = 1'b0;
`endif

  // Once the sequence has been forced without lock, lock_s is no longer trusted.
  assign lock_lost = !lock_s && !timeout_flag;

  // State register plus registered outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= HOLD;
      cnt_q         <= '0;
      rst_core_no   <= 1'b0;
      rst_periph_no <= 1'b0;
      rst_i2c_no    <= 1'b0;
      rst_cause_o   <= 2'b00;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      rst_core_no   <= core_d;
      rst_periph_no <= periph_d;
      rst_i2c_no    <= i2c_d;
      rst_cause_o   <= cause_d;
    end
  end

  // Next-state and counter
  always_comb begin
    state_d    = state_q;
    ev_loss    = 1'b0;
    ev_soft    = 1'b0;
    ev_timeout = 1'b0;
    tc_sel     = STAGE_TC;
    cnt_en     = 1'b1;
    case (state_q)
      HOLD: begin
        cnt_en  = 1'b0;
        state_d = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        tc_sel = LOCK_TC;
`ifdef RST_SEQ_LOCK_TIMEOUT_EN
        if (lock_s) begin
          state_d = FIRST_DLY;
        end else if (cnt_q == LOCK_TC) begin
          state_d    = FIRST_DLY;
          ev_timeout = 1'b1;
        end
`else
        cnt_en = 1'b0;
        if (lock_s) state_d = FIRST_DLY;
`endif
      end
      DLY_CORE: begin
        tc_sel = CORE_TC;
        if (lock_lost)               ev_loss = 1'b1;
        else if (cnt_q == CORE_TC)   state_d = DLY_PERIPH;
      end
      DLY_PERIPH: begin
        if (lock_lost)               ev_loss = 1'b1;
        else if (cnt_q == STAGE_TC)  state_d = DLY_I2C;
      end
      DLY_I2C: begin
        if (lock_lost)               ev_loss = 1'b1;
        else if (cnt_q == STAGE_TC)  state_d = RUN;
      end
      RUN: begin
        cnt_en = 1'b0;
        if (lock_lost) begin
          ev_loss = 1'b1;
        end else if (soft_rst_req_i) begin
          ev_soft = 1'b1;
          state_d = SOFT;
        end
      end
      SOFT: begin
        tc_sel = SOFT_TC;
        if (lock_lost)               ev_loss = 1'b1;
        else if (cnt_q == SOFT_TC)   state_d = WAIT_LOCK;
      end
      default: state_d = HOLD;
    endcase
    if (ev_loss) state_d = WAIT_LOCK;

    cnt_d = cnt_q;
    if (state_d != state_q)             cnt_d = '0;
    else if (cnt_en && cnt_q != tc_sel) cnt_d = cnt_q + 1'b1;
  end

  // Output decode from the next state, so releases land on the transition edge
  always_comb begin
    core_d   = (state_d == DLY_PERIPH) || (state_d == DLY_I2C) || (state_d == RUN);
    periph_d = (state_d == DLY_I2C) || (state_d == RUN);
    i2c_d    = (state_d == RUN);
    cause_d  = rst_cause_o;
    if (ev_loss)         cause_d = CAUSE_LOSS;
    else if (ev_soft)    cause_d = CAUSE_SOFT;
    else if (ev_timeout) cause_d = CAUSE_TIMEOUT;
  end

  assign seq_done_o = (state_q == RUN);

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: expected output changes are queued with their edge number
// and a negedge monitor pops one entry per observed change of the output vector.
module tb_reset_sequencer;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       pll_locked_i = 1'b0;
  logic       soft_rst_req_i = 1'b0;
  logic       rst_core_no, rst_periph_no, rst_i2c_no, seq_done_o, lock_timeout_o;
  logic [1:0] rst_cause_o;

  reset_sequencer #(
    .STAGE_DLY(16), .SOFT_PULSE(8), .LOCK_TIMEOUT(64), .CNT_W(11)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .pll_locked_i(pll_locked_i),
    .soft_rst_req_i(soft_rst_req_i), .rst_core_no(rst_core_no),
    .rst_periph_no(rst_periph_no), .rst_i2c_no(rst_i2c_no),
    .seq_done_o(seq_done_o), .rst_cause_o(rst_cause_o),
    .lock_timeout_o(lock_timeout_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc = cyc + 1;

  typedef struct {
    int         cyc;
    logic [6:0] v;
  } exp_t;
  exp_t exp_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  logic [6:0] out_v;
  assign out_v = {rst_core_no, rst_periph_no, rst_i2c_no, seq_done_o, rst_cause_o, lock_timeout_o};

  function automatic logic [6:0] ov(bit c, bit p, bit i, bit d, logic [1:0] cause, bit to);
    return {c, p, i, d, cause, to};
  endfunction

  function automatic void check(string name, int act, int req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (edge %0d)", name, act, req, cyc);
    end
  endfunction

  function automatic void expect_at(int c, logic [6:0] v);
    exp_q.push_back('{c, v});
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_to(int n);
    while (cyc < n) tick();
  endtask

  // Monitor: every change of the output vector must match the next queued expectation
  logic [6:0] prev = 7'h0;
  exp_t       mon_e;
  always @(negedge clk_i) begin
    if (out_v !== prev) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_change: got %b at edge %0d, required no change from %b", out_v, cyc, prev);
      end else begin
        mon_e = exp_q.pop_front();
        check("change_edge", cyc, mon_e.cyc);
        check("change_value", int'(out_v), int'(mon_e.v));
      end
      prev = out_v;
    end
  end

  int base, d, s, t, r, u;

  initial begin
    repeat (3) tick();
    check("reset_state", int'(out_v), 0);

    // Power-on sequence, with an ignored soft request during DLY_PERIPH
    base = cyc;
    rst_ni = 1'b1;
    expect_at(base + 28, ov(1, 0, 0, 0, 2'b00, 0));
    expect_at(base + 44, ov(1, 1, 0, 0, 2'b00, 0));
    expect_at(base + 60, ov(1, 1, 1, 1, 2'b00, 0));
    wait_to(base + 10);
    pll_locked_i = 1'b1;
    wait_to(base + 30);
    soft_rst_req_i = 1'b1;
    tick();
    soft_rst_req_i = 1'b0;
    wait_to(base + 65);
    check("poweron_done", int'(seq_done_o), 1);

    // Lock loss in RUN, relock 20 cycles later
    d = cyc;
    pll_locked_i = 1'b0;
    expect_at(d + 3,  ov(0, 0, 0, 0, 2'b01, 0));
    expect_at(d + 38, ov(1, 0, 0, 0, 2'b01, 0));
    expect_at(d + 54, ov(1, 1, 0, 0, 2'b01, 0));
    expect_at(d + 70, ov(1, 1, 1, 1, 2'b01, 0));
    wait_to(d + 20);
    pll_locked_i = 1'b1;
    wait_to(d + 75);

    // Soft request in RUN
    s = cyc;
    soft_rst_req_i = 1'b1;
    expect_at(s + 1,  ov(0, 0, 0, 0, 2'b10, 0));
    expect_at(s + 25, ov(1, 0, 0, 0, 2'b10, 0));
    expect_at(s + 41, ov(1, 1, 0, 0, 2'b10, 0));
    expect_at(s + 57, ov(1, 1, 1, 1, 2'b10, 0));
    tick();
    soft_rst_req_i = 1'b0;
    wait_to(s + 62);

    // Lock loss and soft request seen in the same RUN cycle, then async reset in DLY_I2C
    t = cyc;
    pll_locked_i = 1'b0;
    expect_at(t + 3,  ov(0, 0, 0, 0, 2'b01, 0));
    expect_at(t + 23, ov(1, 0, 0, 0, 2'b01, 0));
    expect_at(t + 39, ov(1, 1, 0, 0, 2'b01, 0));
    wait_to(t + 2);
    soft_rst_req_i = 1'b1;
    tick();
    soft_rst_req_i = 1'b0;
    wait_to(t + 5);
    pll_locked_i = 1'b1;
    wait_to(t + 45);
    rst_ni = 1'b0;
    expect_at(t + 45, ov(0, 0, 0, 0, 2'b00, 0));
    #1;
    check("async_reset", int'(out_v), 0);
    wait_to(t + 47);
    r = cyc;
    rst_ni = 1'b1;
    expect_at(r + 18, ov(1, 0, 0, 0, 2'b00, 0));
    expect_at(r + 34, ov(1, 1, 0, 0, 2'b00, 0));
    expect_at(r + 50, ov(1, 1, 1, 1, 2'b00, 0));
    wait_to(r + 55);

    // PLL held low: forced sequence when the timeout is built in, otherwise an indefinite wait
    u = cyc;
    pll_locked_i = 1'b0;
    expect_at(u + 3, ov(0, 0, 0, 0, 2'b01, 0));
`ifdef RST_SEQ_LOCK_TIMEOUT_EN
    expect_at(u + 67,  ov(0, 0, 0, 0, 2'b11, 1));
    expect_at(u + 82,  ov(1, 0, 0, 0, 2'b11, 1));
    expect_at(u + 98,  ov(1, 1, 0, 0, 2'b11, 1));
    expect_at(u + 114, ov(1, 1, 1, 1, 2'b11, 1));
    wait_to(u + 120);
    check("timeout_flag", int'(lock_timeout_o), 1);
    check("timeout_done", int'(seq_done_o), 1);
`else
    wait_to(u + 200);
    check("no_timeout_flag", int'(lock_timeout_o), 0);
    check("still_waiting", int'(rst_core_no), 0);
`endif

    repeat (4) tick();
    while (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      n_cmp++;
      n_bad++;
      $display("FAIL missing_change: nothing seen, required %b at edge %0d", mon_e.v, mon_e.cyc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
